// File: rtl/mod_counter_pkg.sv
// Shared constants and the wrapped next-value helper for the modulo up/down counter.
package mod_counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam int DEFAULT_WIDTH   = 4;
  localparam int DEFAULT_MODULUS = 10;

  // Wrap is explicit at both ends; callers truncate back to their own width.
  function automatic logic [31:0] next_count(input logic [31:0] count,
                                             input logic        up,
                                             input logic [31:0] modulus);
    if (up == DIR_UP)
      return (count == modulus - 32'd1) ? 32'd0 : count + 32'd1;
    else
      return (count == 32'd0) ? modulus - 32'd1 : count - 32'd1;
  endfunction

endpackage

// File: rtl/mod_updown_counter_count_reg.sv
// WIDTH-bit state register with asynchronous active-low clear.
module count_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             res,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge res) begin
    if (!res) q <= '0;
    else      q <= d;
  end

endmodule

// File: rtl/mod_updown_counter.sv
// Modulo-N up/down counter with clamped parallel load, terminal count and wrap pulse.
// Define MOD_COUNTER_SATURATE_EN to saturate at the range ends instead of wrapping.
module mod_updown_counter
  import mod_counter_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int MODULUS = DEFAULT_MODULUS
) (
  input  logic             clk,
  input  logic             res,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap
);

  if (MODULUS < 2 || longint'(MODULUS) > (longint'(1) << WIDTH)) begin : g_bad_modulus
    $error("mod_updown_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
  end

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] d;
  logic             at_end;

  assign at_end = (up == DIR_UP) ? (count == MAX_V) : (count == '0);
  assign tc     = en & ~load & at_end;

`ifdef MOD_COUNTER_SATURATE_EN
  always_comb begin
    d = count;
    if (load)
      d = (din > MAX_V) ? MAX_V : din;
    else if (en && !at_end)
      d = WIDTH'(next_count(32'(count), up, 32'(MODULUS)));
  end

  assign wrap = 1'b0;
`else
  logic wrap_d;

  always_comb begin
    d      = count;
    wrap_d = 1'b0;
    if (load)
      d = (din > MAX_V) ? MAX_V : din;
    else if (en) begin
      d      = WIDTH'(next_count(32'(count), up, 32'(MODULUS)));
      wrap_d = at_end;
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) wrap <= 1'b0;
    else      wrap <= wrap_d;
  end
`endif

  count_reg #(.WIDTH(WIDTH)) u_count_reg (
    .clk (clk),
    .res (res),
    .d   (d),
    .q   (count)
  );

endmodule
